aes_host_driver: RTL and testbench
==================================

Name: aes_host_driver

Overview:
Host-side initiator for the pin-limited AES wrapper bus, which uses a 4-bit address, a 16-bit write bus and an 8-bit read bus. It accepts a full AES job (key, key length, mode, block) over a valid/ready command port. It sequences CONFIG, KEY, BLOCK, START-init, STATUS poll, START-next, STATUS poll and RESULT read, then returns the 128-bit result on a valid/ready response port. It sits in the test chip's host FPGA, or in an on-chip CPU bridge, facing the AES wrapper pins.

Parameters:
RD_LAT, 1, cycles from address presented to the matching byte valid on aes_rdata
POLL_MAX, 1024, maximum STATUS poll cycles per poll phase (used only with AES_DRV_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous active-low
cmd_valid  in  1  job request
cmd_ready  out  1  high only in IDLE
cmd_encdec  in  1  1=encrypt, 0=decrypt
cmd_keylen  in  1  0=128-bit, 1=256-bit
cmd_reuse_key  in  1  skip CONFIG/KEY/INIT; use the previously expanded key
cmd_key  in  256  key; 128-bit keys occupy [255:128]
cmd_block  in  128  input block
rsp_valid  out  1  result available
rsp_ready  in  1  result accepted
rsp_result  out  128  result block
rsp_error  out  1  poll timeout (see Optional Feature); 0 otherwise
aes_addr  out  4  wrapper address pins
aes_wdata  out  16  wrapper 16-bit write bus
aes_rdata  in  8  wrapper 8-bit read bus
busy  out  1  high whenever not in IDLE

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE. aes_addr=0, aes_wdata=0, rsp_valid=0, rsp_result=0, rsp_error=0, busy=0, key_loaded=0. Reset mid-job abandons the job with no further bus activity.
- Command fields are latched on the cmd_valid&&cmd_ready edge. The command inputs are ignored until the next IDLE.
- Address codes: CONFIG=1, KEY=2, BLOCK=3, STATUS=4, RESULT=5, START=F, IDLE=0. aes_addr and aes_wdata are registered outputs.
- Each phase ends with exactly one gap cycle, during which aes_addr=0 and aes_wdata=0.
- States and bus activity:
  - CFG: 1 cycle, addr=1, wdata={14'b0, keylen, encdec}.
  - KEY: N cycles, addr=2 held, wdata=16-bit key words MSW first. N=8 for 128-bit keys, N=16 for 256-bit keys.
  - BLK: 8 cycles, addr=3 held, block words MSW first.
  - INIT: 1 cycle, addr=F, wdata=0x0001.
  - POLL_RDY: addr=4 held. From RD_LAT cycles after entry, aes_rdata[0] is sampled every cycle. The first 1 exits the state.
  - NEXT: 1 cycle, addr=F, wdata=0x0002.
  - POLL_VLD: same as POLL_RDY, but on aes_rdata[1].
  - READ: addr=5 held for 16 cycles. Byte k, sampled RD_LAT cycles after the k-th address cycle, fills result[127-8k -: 8]. The state lasts 16+RD_LAT cycles.
  - RESP: rsp_valid=1 until rsp_ready, then IDLE.
- Order with cmd_reuse_key=0: CFG, KEY, BLK, INIT, POLL_RDY, NEXT, POLL_VLD, READ, RESP.
- Order with cmd_reuse_key=1 and key_loaded=1: BLK, NEXT, POLL_VLD, READ, RESP. CONFIG is still written first if cmd_encdec differs from the last written value.
- cmd_reuse_key=1 while key_loaded=0 is treated as reuse=0.
- key_loaded is set on leaving POLL_RDY successfully and cleared by reset.
- rsp_result and rsp_valid stay stable while rsp_valid&&!rsp_ready.
- The next command can be accepted the cycle after the RESP handshake. cmd_ready is low in RESP.
- A word or byte counter wraps to 0 at the end of each phase. There is no carry between phases.

Optional Feature:
- Macro: AES_DRV_TIMEOUT_EN.
- Defined: each poll phase counts cycles. Reaching POLL_MAX without the bit set gives a gap cycle, then RESP with rsp_result=0, rsp_error=1 and key_loaded=0.
- Undefined: polls indefinitely; rsp_error is tied 0.

Decomposition:
- Package aes_bus_pkg holds:
  - address codes
  - CONFIG/START/STATUS bit indices
  - word counts for key128, key256 and block
  - the driver state enum
- One natural sub-module: aes_rd_sampler. It is an RD_LAT-deep shift of strobe/index that produces sample-enable and byte index for the poll and read phases.

Test Plan:
- FIPS-197 AES-128, encrypt: key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff, against a wrapper model -> rsp_result 69c4e0d86a7b0430d8cdb78070b4c55a. Bus trace checks CONFIG wdata 0x0001, 8 KEY words starting 0x0001, and INIT 0x0001.
- Same key, decrypt of 69c4...c55a with cmd_reuse_key=1 -> CONFIG rewritten as 0x0000, no KEY or INIT phase, result 00112233...eeff.
- AES-256, key 000102...1e1f, block 00112233...eeff -> 16 KEY words, CONFIG 0x0003, result 8ea2b7ca516745bfeafc49904b496089.
- rsp_ready held low 20 cycles -> rsp_valid and rsp_result stable. cmd_ready rises the cycle after the handshake.
- rst_n low during the KEY word 5 cycle -> next cycle aes_addr=0, busy=0. A following job with reuse=1 performs a full key load.
- AES_DRV_TIMEOUT_EN with POLL_MAX=16 and the model never setting ready -> rsp_error=1, rsp_result=0 after 16 poll cycles.

Source files
------------

// File: rtl/aes_bus_pkg.sv
// Shared constants for the pin-limited AES wrapper bus and its host driver:
// address codes, register bit indices, phase word counts and state codes.
package aes_bus_pkg;

    localparam logic [3:0] A_IDLE   = 4'h0;
    localparam logic [3:0] A_CONFIG = 4'h1;
    localparam logic [3:0] A_KEY    = 4'h2;
    localparam logic [3:0] A_BLOCK  = 4'h3;
    localparam logic [3:0] A_STATUS = 4'h4;
    localparam logic [3:0] A_RESULT = 4'h5;
    localparam logic [3:0] A_START  = 4'hF;

    localparam int CFG_ENCDEC_BIT = 0;
    localparam int CFG_KEYLEN_BIT = 1;
    localparam int START_INIT_BIT = 0;
    localparam int START_NEXT_BIT = 1;
    localparam int STAT_READY_BIT = 0;
    localparam int STAT_VALID_BIT = 1;

    localparam int KEY128_WORDS = 8;
    localparam int KEY256_WORDS = 16;
    localparam int BLOCK_WORDS  = 8;
    localparam int RESULT_BYTES = 16;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_CFG      = 4'd1;
    localparam logic [3:0] S_KEY      = 4'd2;
    localparam logic [3:0] S_BLK      = 4'd3;
    localparam logic [3:0] S_INIT     = 4'd4;
    localparam logic [3:0] S_POLL_RDY = 4'd5;
    localparam logic [3:0] S_NEXT     = 4'd6;
    localparam logic [3:0] S_POLL_VLD = 4'd7;
    localparam logic [3:0] S_READ     = 4'd8;
    localparam logic [3:0] S_RESP     = 4'd9;
    localparam logic [3:0] S_GAP      = 4'd10;

endpackage

// File: rtl/aes_host_driver_rd_sampler.sv
// Delays the read strobe and byte index by RD_LAT cycles so the driver
// knows when aes_rdata holds the answer to an earlier STATUS/RESULT address.
module aes_rd_sampler #(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       strobe,
    input  logic [3:0] idx,
    output logic       s_en,
    output logic [3:0] s_idx
);

    generate
        if (RD_LAT == 0) begin : g_comb
            assign s_en  = strobe;
            assign s_idx = idx;
        end else begin : g_pipe
            logic [RD_LAT-1:0] en_q;
            logic [3:0]        idx_q [RD_LAT];

            // Shift strobe/index; cleared on phase entry to drop stale reads.
            always_ff @(posedge clk) begin
                if (!rst_n || clr) begin
                    en_q <= '0;
                    for (int i = 0; i < RD_LAT; i++) idx_q[i] <= '0;
                end else begin
                    en_q[0]  <= strobe;
                    idx_q[0] <= idx;
                    for (int i = 1; i < RD_LAT; i++) begin
                        en_q[i]  <= en_q[i-1];
                        idx_q[i] <= idx_q[i-1];
                    end
                end
            end

            assign s_en  = en_q[RD_LAT-1];
            assign s_idx = idx_q[RD_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/aes_host_driver.sv
// Host-side job sequencer for the pin-limited AES wrapper bus.
// Optional poll timeout: define AES_DRV_TIMEOUT_EN.
module aes_host_driver
    import aes_bus_pkg::*;
#(
    parameter int RD_LAT   = 1,
    parameter int POLL_MAX = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_encdec,
    input  logic         cmd_keylen,
    input  logic         cmd_reuse_key,
    input  logic [255:0] cmd_key,
    input  logic [127:0] cmd_block,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_result,
    output logic         rsp_error,
    output logic [3:0]   aes_addr,
    output logic [15:0]  aes_wdata,
    input  logic [7:0]   aes_rdata,
    output logic         busy
);

    localparam int CW = $clog2(POLL_MAX + RD_LAT + 32);
    localparam logic [CW-1:0] READ_LAST = CW'(RESULT_BYTES + RD_LAT - 1);
    localparam logic [CW-1:0] RD_BYTES  = CW'(RESULT_BYTES);
    localparam logic [CW-1:0] BLK_LAST  = CW'(BLOCK_WORDS - 1);
    localparam logic [CW-1:0] K128_LAST = CW'(KEY128_WORDS - 1);
    localparam logic [CW-1:0] K256_LAST = CW'(KEY256_WORDS - 1);
`ifdef AES_DRV_TIMEOUT_EN
    localparam logic [CW-1:0] POLL_LAST = CW'(POLL_MAX - 1);
    logic timeout;
`endif

    logic [3:0]    state, state_n, ret, ret_n;
    logic [CW-1:0] cnt, cnt_n, key_last;
    logic          r_encdec, r_keylen, r_reuse;
    logic [255:0]  r_key;
    logic [127:0]  r_block;
    logic          key_loaded, last_enc;
    logic          accept, full, poll_bit, poll_hit, strobe;
    logic          j_encdec, j_keylen;
    logic [255:0]  j_key;
    logic [127:0]  j_block;
    logic          s_en;
    logic [3:0]    s_idx;
    logic [3:0]    addr_n;
    logic [15:0]   wdata_n;

    assign cmd_ready = (state == S_IDLE);
    assign full      = !(cmd_reuse_key && key_loaded);
    assign key_last  = r_keylen ? K256_LAST : K128_LAST;

    // Job fields come straight from the command port on the accept edge.
    assign j_encdec = cmd_ready ? cmd_encdec : r_encdec;
    assign j_keylen = cmd_ready ? cmd_keylen : r_keylen;
    assign j_key    = cmd_ready ? cmd_key    : r_key;
    assign j_block  = cmd_ready ? cmd_block  : r_block;

    assign poll_bit = (state == S_POLL_RDY) ? aes_rdata[STAT_READY_BIT]
                                            : aes_rdata[STAT_VALID_BIT];
    assign poll_hit = s_en && poll_bit;

    assign strobe = (state == S_POLL_RDY) || (state == S_POLL_VLD) ||
                    ((state == S_READ) && (cnt < RD_BYTES));

    aes_rd_sampler #(
        .RD_LAT(RD_LAT)
    ) u_sampler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_n != state),
        .strobe(strobe),
        .idx   (cnt[3:0]),
        .s_en  (s_en),
        .s_idx (s_idx)
    );

    // Phase sequencing; every phase hands off through one GAP cycle.
    always_comb begin
        state_n = state;
        ret_n   = ret;
        cnt_n   = cnt;
        accept  = 1'b0;
`ifdef AES_DRV_TIMEOUT_EN
        timeout = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    cnt_n  = '0;
                    if (full || (cmd_encdec != last_enc)) state_n = S_CFG;
                    else state_n = S_BLK;
                end
            end
            S_CFG: begin
                state_n = S_GAP;
                ret_n   = r_reuse ? S_BLK : S_KEY;
            end
            S_KEY: begin
                if (cnt == key_last) begin
                    state_n = S_GAP;
                    ret_n   = S_BLK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_BLK: begin
                if (cnt == BLK_LAST) begin
                    state_n = S_GAP;
                    ret_n   = r_reuse ? S_NEXT : S_INIT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_INIT: begin
                state_n = S_GAP;
                ret_n   = S_POLL_RDY;
            end
            S_NEXT: begin
                state_n = S_GAP;
                ret_n   = S_POLL_VLD;
            end
            S_POLL_RDY, S_POLL_VLD: begin
                if (poll_hit) begin
                    state_n = S_GAP;
                    ret_n   = (state == S_POLL_RDY) ? S_NEXT : S_READ;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
`ifdef AES_DRV_TIMEOUT_EN
                    if (cnt == POLL_LAST) begin
                        timeout = 1'b1;
                        state_n = S_GAP;
                        ret_n   = S_RESP;
                        cnt_n   = '0;
                    end
`endif
                end
            end
            S_READ: begin
                if (cnt == READ_LAST) begin
                    state_n = S_GAP;
                    ret_n   = S_RESP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_n = S_IDLE;
            end
            S_GAP: begin
                state_n = ret;
                cnt_n   = '0;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Bus value for the upcoming cycle, registered below.
    always_comb begin
        addr_n  = A_IDLE;
        wdata_n = '0;
        case (state_n)
            S_CFG: begin
                addr_n = A_CONFIG;
                wdata_n[CFG_ENCDEC_BIT] = j_encdec;
                wdata_n[CFG_KEYLEN_BIT] = j_keylen;
            end
            S_KEY: begin
                addr_n  = A_KEY;
                wdata_n = j_key[{~cnt_n[3:0], 4'b0000} +: 16];
            end
            S_BLK: begin
                addr_n  = A_BLOCK;
                wdata_n = j_block[{~cnt_n[2:0], 4'b0000} +: 16];
            end
            S_INIT: begin
                addr_n = A_START;
                wdata_n[START_INIT_BIT] = 1'b1;
            end
            S_NEXT: begin
                addr_n = A_START;
                wdata_n[START_NEXT_BIT] = 1'b1;
            end
            S_POLL_RDY, S_POLL_VLD: addr_n = A_STATUS;
            S_READ: begin
                if (cnt_n < RD_BYTES) addr_n = A_RESULT;
            end
            default: addr_n = A_IDLE;
        endcase
    end

    // State, registered bus outputs, job latch and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ret        <= S_IDLE;
            cnt        <= '0;
            aes_addr   <= A_IDLE;
            aes_wdata  <= '0;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            key_loaded <= 1'b0;
            last_enc   <= 1'b0;
            r_encdec   <= 1'b0;
            r_keylen   <= 1'b0;
            r_reuse    <= 1'b0;
            r_key      <= '0;
            r_block    <= '0;
`ifdef AES_DRV_TIMEOUT_EN
            rsp_error  <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            ret       <= ret_n;
            cnt       <= cnt_n;
            aes_addr  <= addr_n;
            aes_wdata <= wdata_n;
            busy      <= (state_n != S_IDLE);
            rsp_valid <= (state_n == S_RESP);
            if (accept) begin
                r_encdec <= cmd_encdec;
                r_keylen <= cmd_keylen;
                r_key    <= cmd_key;
                r_block  <= cmd_block;
                r_reuse  <= !full;
                if (full) key_loaded <= 1'b0;
`ifdef AES_DRV_TIMEOUT_EN
                rsp_error <= 1'b0;
`endif
            end
            if (state == S_CFG) last_enc <= r_encdec;
            if ((state == S_POLL_RDY) && poll_hit) key_loaded <= 1'b1;
            if ((state == S_READ) && s_en)
                rsp_result[{~s_idx, 3'b000} +: 8] <= aes_rdata;
`ifdef AES_DRV_TIMEOUT_EN
            if (timeout) begin
                rsp_result <= '0;
                rsp_error  <= 1'b1;
                key_loaded <= 1'b0;
            end
`endif
        end
    end

`ifndef AES_DRV_TIMEOUT_EN
    assign rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_aes_host_driver.sv
// Directed bench for aes_host_driver against a small AES wrapper model
// that answers known FIPS-197 vectors and traces the bus.
module tb_aes_host_driver;

    localparam int RD_LAT   = 1;
    localparam int POLL_MAX = 16;

    localparam logic [255:0] K128 =
        {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_encdec = 1'b0;
    logic         cmd_keylen = 1'b0;
    logic         cmd_reuse_key = 1'b0;
    logic [255:0] cmd_key = '0;
    logic [127:0] cmd_block = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [127:0] rsp_result;
    logic         rsp_error;
    logic [3:0]   aes_addr;
    logic [15:0]  aes_wdata;
    logic [7:0]   aes_rdata = '0;
    logic         busy;

    always #5 clk = ~clk;

    aes_host_driver #(
        .RD_LAT  (RD_LAT),
        .POLL_MAX(POLL_MAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_encdec   (cmd_encdec),
        .cmd_keylen   (cmd_keylen),
        .cmd_reuse_key(cmd_reuse_key),
        .cmd_key      (cmd_key),
        .cmd_block    (cmd_block),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_error    (rsp_error),
        .aes_addr     (aes_addr),
        .aes_wdata    (aes_wdata),
        .aes_rdata    (aes_rdata),
        .busy         (busy)
    );

    // ---------------- wrapper model ----------------
    logic [15:0]  m_cfg = '0;
    logic [15:0]  m_first_kw = '0;
    logic [255:0] m_keysh = '0;
    logic [255:0] m_xkey = '0;
    logic [127:0] m_blk = '0;
    logic [127:0] m_res = '0;
    logic         m_rdy = 1'b0;
    logic         m_vld = 1'b0;
    logic         m_never_rdy = 1'b0;
    logic [3:0]   prev_addr = '0;
    int m_cfg_cnt = 0, m_key_cnt = 0, m_blk_cnt = 0;
    int m_init_cnt = 0, m_next_cnt = 0, m_poll_cnt = 0;
    int m_rdy_dly = 0, m_vld_dly = 0, m_rd_idx = 0, viol = 0;

    function automatic logic [127:0] aes_ref(input logic enc,
                                             input logic kl,
                                             input logic [255:0] k,
                                             input logic [127:0] b);
        if (!kl && k == K128 && enc && b == PT) return CT128;
        if (!kl && k == K128 && !enc && b == CT128) return PT;
        if (kl && k == K256 && enc && b == PT) return CT256;
        if (kl && k == K256 && !enc && b == CT256) return PT;
        return ~b;
    endfunction

    always @(posedge clk) begin
        prev_addr <= aes_addr;
        viol <= viol
              + int'(prev_addr != 0 && aes_addr != 0 && aes_addr != prev_addr)
              + int'(aes_addr == 0 && aes_wdata != 0);
        if (m_rdy_dly > 0) begin
            m_rdy_dly <= m_rdy_dly - 1;
            if (m_rdy_dly == 1 && !m_never_rdy) m_rdy <= 1'b1;
        end
        if (m_vld_dly > 0) begin
            m_vld_dly <= m_vld_dly - 1;
            if (m_vld_dly == 1) m_vld <= 1'b1;
        end
        case (aes_addr)
            4'h1: begin
                m_cfg <= aes_wdata;
                m_cfg_cnt <= m_cfg_cnt + 1;
            end
            4'h2: begin
                m_keysh <= {m_keysh[239:0], aes_wdata};
                m_key_cnt <= m_key_cnt + 1;
                if (prev_addr != 4'h2) m_first_kw <= aes_wdata;
            end
            4'h3: begin
                m_blk <= {m_blk[111:0], aes_wdata};
                m_blk_cnt <= m_blk_cnt + 1;
            end
            4'h4: m_poll_cnt <= m_poll_cnt + 1;
            4'hF: begin
                if (aes_wdata == 16'h0001) begin
                    m_init_cnt <= m_init_cnt + 1;
                    m_xkey <= m_cfg[1] ? m_keysh : {m_keysh[127:0], 128'h0};
                    m_rdy <= 1'b0;
                    m_rdy_dly <= 3;
                end
                if (aes_wdata == 16'h0002) begin
                    m_next_cnt <= m_next_cnt + 1;
                    m_res <= aes_ref(m_cfg[0], m_cfg[1], m_xkey, m_blk);
                    m_vld <= 1'b0;
                    m_vld_dly <= 5;
                end
            end
            default: ;
        endcase
        if (aes_addr == 4'h5) begin
            aes_rdata <= m_res[8*(15-m_rd_idx) +: 8];
            m_rd_idx <= m_rd_idx + 1;
        end else begin
            aes_rdata <= (aes_addr == 4'h4) ? {6'b0, m_vld, m_rdy} : 8'h00;
            m_rd_idx <= 0;
        end
    end

    // ---------------- checking ----------------
    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic         enc;
        logic         kl;
        logic         reuse;
        logic [255:0] key;
        logic [127:0] blk;
        logic [127:0] res;
        int           cfg_n;
        logic [15:0]  cfg;
        int           key_n;
        int           init_n;
    } vec_t;

    vec_t vt [5];

    // Entered at a negedge; returns at a negedge after the accept edge.
    task automatic send_cmd(input vec_t v);
        bit ok;
        ok = 0;
        cmd_encdec    = v.enc;
        cmd_keylen    = v.kl;
        cmd_reuse_key = v.reuse;
        cmd_key       = v.key;
        cmd_block     = v.blk;
        cmd_valid     = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (cmd_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("cmd_accept", 256'(ok), 256'(1));
    endtask

    task automatic wait_rsp();
        bit ok;
        ok = 0;
        for (int n = 0; n < 1000; n++) begin
            if (rsp_valid) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("rsp_valid_seen", 256'(ok), 256'(1));
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    int b_cfg, b_key, b_blk, b_init, b_next, b_poll;

    task automatic snap();
        b_cfg  = m_cfg_cnt;
        b_key  = m_key_cnt;
        b_blk  = m_blk_cnt;
        b_init = m_init_cnt;
        b_next = m_next_cnt;
        b_poll = m_poll_cnt;
    endtask

    logic [127:0] r0;
    logic         e0;
    int           bad;
    bit           found;

    initial begin
        vt[0] = '{1'b1, 1'b0, 1'b0, K128, PT, CT128, 1, 16'h0001, 8, 1};
        vt[1] = '{1'b0, 1'b0, 1'b1, K128, CT128, PT, 1, 16'h0000, 0, 0};
        vt[2] = '{1'b0, 1'b0, 1'b1, K128, CT128, PT, 0, 16'h0000, 0, 0};
        vt[3] = '{1'b1, 1'b1, 1'b0, K256, PT, CT256, 1, 16'h0003, 16, 1};
        vt[4] = '{1'b1, 1'b1, 1'b1, K256, PT, CT256, 0, 16'h0003, 0, 0};

        repeat (3) @(negedge clk);
        chk("rst_addr", 256'(aes_addr), 256'(0));
        chk("rst_wdata", 256'(aes_wdata), 256'(0));
        chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
        chk("rst_result", 256'(rsp_result), 256'(0));
        chk("rst_error", 256'(rsp_error), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", 256'(cmd_ready), 256'(1));

        for (int i = 0; i < 5; i++) begin
            snap();
            send_cmd(vt[i]);
            chk($sformatf("v%0d_busy", i), 256'(busy), 256'(1));
            wait_rsp();
            r0 = rsp_result;
            e0 = rsp_error;
            ack();
            chk($sformatf("v%0d_result", i), 256'(r0), 256'(vt[i].res));
            chk($sformatf("v%0d_error", i), 256'(e0), 256'(0));
            chk($sformatf("v%0d_cfg_writes", i),
                256'(m_cfg_cnt - b_cfg), 256'(vt[i].cfg_n));
            chk($sformatf("v%0d_cfg_value", i), 256'(m_cfg), 256'(vt[i].cfg));
            chk($sformatf("v%0d_key_words", i),
                256'(m_key_cnt - b_key), 256'(vt[i].key_n));
            chk($sformatf("v%0d_init_writes", i),
                256'(m_init_cnt - b_init), 256'(vt[i].init_n));
            chk($sformatf("v%0d_blk_words", i),
                256'(m_blk_cnt - b_blk), 256'(8));
            chk($sformatf("v%0d_next_writes", i),
                256'(m_next_cnt - b_next), 256'(1));
            if (vt[i].key_n > 0)
                chk($sformatf("v%0d_first_key_word", i),
                    256'(m_first_kw), 256'(16'h0001));
        end

        // Back-pressure: response must hold while rsp_ready is low.
        send_cmd(vt[0]);
        wait_rsp();
        r0 = rsp_result;
        chk("bp_result", 256'(r0), 256'(CT128));
        chk("bp_cmd_ready_low", 256'(cmd_ready), 256'(0));
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            if (!(rsp_valid === 1'b1 && rsp_result === r0)) bad++;
            @(negedge clk);
        end
        chk("bp_stable", 256'(bad), 256'(0));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_valid_drop", 256'(rsp_valid), 256'(0));
        chk("bp_cmd_ready_rise", 256'(cmd_ready), 256'(1));
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset during KEY word 5, then a reuse request must reload the key.
        send_cmd(vt[0]);
        found = 0;
        for (int n = 0; n < 100; n++) begin
            if (aes_addr == 4'h2 && aes_wdata == 16'h0a0b) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_key5_found", 256'(found), 256'(1));
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_addr", 256'(aes_addr), 256'(0));
        chk("midrst_busy", 256'(busy), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);
        snap();
        send_cmd('{1'b1, 1'b0, 1'b1, K128, PT, CT128, 1, 16'h0001, 8, 1});
        wait_rsp();
        r0 = rsp_result;
        ack();
        chk("postrst_result", 256'(r0), 256'(CT128));
        chk("postrst_key_words", 256'(m_key_cnt - b_key), 256'(8));
        chk("postrst_init", 256'(m_init_cnt - b_init), 256'(1));

`ifdef AES_DRV_TIMEOUT_EN
        m_never_rdy = 1'b1;
        snap();
        send_cmd(vt[0]);
        wait_rsp();
        r0 = rsp_result;
        e0 = rsp_error;
        ack();
        chk("to_error", 256'(e0), 256'(1));
        chk("to_result", 256'(r0), 256'(0));
        chk("to_poll_cycles", 256'(m_poll_cnt - b_poll), 256'(POLL_MAX));
        m_never_rdy = 1'b0;
        snap();
        send_cmd('{1'b1, 1'b0, 1'b1, K128, PT, CT128, 1, 16'h0001, 8, 1});
        wait_rsp();
        r0 = rsp_result;
        e0 = rsp_error;
        ack();
        chk("to_reload_keys", 256'(m_key_cnt - b_key), 256'(8));
        chk("to_reload_result", 256'(r0), 256'(CT128));
        chk("to_reload_error", 256'(e0), 256'(0));
`endif

        chk("gap_protocol", 256'(viol), 256'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
